// File: rtl/mem_stage_lsu_if.sv
// Data-bus channel between the memory-stage LSU and data memory:
// valid/ready request, rvalid read response.
interface mem_stage_lsu_if #(
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
);
    logic              dbus_valid;
    logic              dbus_ready;
    logic              dbus_we;
    logic [DATA_W-1:0] dbus_addr;
    logic [DATA_W-1:0] dbus_wdata;
    logic [BE_W-1:0]   dbus_be;
    logic              dbus_rvalid;
    logic [DATA_W-1:0] dbus_rdata;

    modport master (
        output dbus_valid,
        output dbus_we,
        output dbus_addr,
        output dbus_wdata,
        output dbus_be,
        input  dbus_ready,
        input  dbus_rvalid,
        input  dbus_rdata
    );

    modport slave (
        input  dbus_valid,
        input  dbus_we,
        input  dbus_addr,
        input  dbus_wdata,
        input  dbus_be,
        output dbus_ready,
        output dbus_rvalid,
        output dbus_rdata
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: one bus access per load/store, stalls M.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning.
module mem_stage_lsu #(
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] rdata2M,
    input  logic [4:0]        waddrM,
    mem_stage_lsu_if.master   dbus,
    output logic [DATA_W-1:0] LoadDataM,
    output logic [4:0]        LoadWaddrM,
    output logic              load_done,
    output logic              lsu_stall,
    output logic              misalign_fault
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              req_in;
    logic              is_byte;
    logic              is_half;
    logic              is_word;
    logic              trap;
    logic [1:0]        off;
    logic [BE_W-1:0]   be_fmt;
    logic [DATA_W-1:0] wdata_fmt;

    logic [DATA_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;
    logic [4:0]        waddr_q;
    logic [1:0]        sz_q;
    logic              uns_q;
    logic [1:0]        off_q;
    logic              ld_q;
    logic              flt_q;

    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [DATA_W-1:0] ext;

    assign req_in  = MemReadM | MemWriteM;
    assign is_byte = ~funct3M[1] & ~funct3M[0];
    assign is_half = ~funct3M[1] &  funct3M[0];
    assign is_word =  funct3M[1];

`ifdef MISALIGN_TRAP_EN
    assign trap = (is_half & ALUResultM[0])
                | (is_word & (|ALUResultM[1:0]));
`else
    assign trap = 1'b0;
`endif

    // Low address bits an access may legally use; the rest are dropped.
    always_comb begin
        off = 2'b00;
        unique case (1'b1)
            is_byte: off = ALUResultM[1:0];
            is_half: off = {ALUResultM[1], 1'b0};
            default: off = 2'b00;
        endcase
    end

    always_comb begin
        be_fmt    = '1;
        wdata_fmt = rdata2M;
        if (MemWriteM) begin
            unique case (1'b1)
                is_byte: begin
                    be_fmt    = 4'b0001 << off;
                    wdata_fmt = {4{rdata2M[7:0]}};
                end
                is_half: begin
                    be_fmt    = 4'b0011 << off;
                    wdata_fmt = {2{rdata2M[15:0]}};
                end
                default: begin
                    be_fmt    = '1;
                    wdata_fmt = rdata2M;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        lsu_stall       = 1'b0;
        dbus.dbus_valid = 1'b0;
        load_done       = 1'b0;
        misalign_fault  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_in) begin
                    lsu_stall = 1'b1;
                    state_nxt = trap ? DONE : REQ;
                end
            end
            REQ: begin
                lsu_stall       = 1'b1;
                dbus.dbus_valid = 1'b1;
                if (dbus.dbus_ready) begin
                    state_nxt = we_q ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                lsu_stall = 1'b1;
                if (dbus.dbus_rvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load_done      = ld_q;
                misalign_fault = flt_q;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Keep every output quiet while reset is held.
        if (rst) begin
            lsu_stall = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            waddr_q <= '0;
            sz_q    <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            ld_q    <= 1'b0;
            flt_q   <= 1'b0;
        end else if (state == IDLE && req_in) begin
            addr_q  <= {ALUResultM[DATA_W-1:2], 2'b00};
            we_q    <= MemWriteM;
            wdata_q <= wdata_fmt;
            be_q    <= be_fmt;
            waddr_q <= waddrM;
            sz_q    <= is_word ? 2'd2 : funct3M[1:0];
            uns_q   <= funct3M[2];
            off_q   <= off;
            ld_q    <= ~MemWriteM & ~trap;
            flt_q   <= trap;
        end
    end

    assign dbus.dbus_addr  = addr_q;
    assign dbus.dbus_we    = we_q;
    assign dbus.dbus_wdata = wdata_q;
    assign dbus.dbus_be    = be_q;

    always_comb begin
        lane_b = dbus.dbus_rdata[7:0];
        unique case (off_q)
            2'd0:    lane_b = dbus.dbus_rdata[7:0];
            2'd1:    lane_b = dbus.dbus_rdata[15:8];
            2'd2:    lane_b = dbus.dbus_rdata[23:16];
            default: lane_b = dbus.dbus_rdata[31:24];
        endcase
        lane_h = off_q[1] ? dbus.dbus_rdata[31:16]
                          : dbus.dbus_rdata[15:0];
        ext = dbus.dbus_rdata;
        unique case (sz_q)
            2'd0:    ext = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'd1:    ext = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: ext = dbus.dbus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            LoadDataM  <= '0;
            LoadWaddrM <= '0;
        end else if (state == WAIT_R && dbus.dbus_rvalid) begin
            LoadDataM  <= ext;
            LoadWaddrM <= waddr_q;
        end
    end

endmodule
